bypass_scoreboard: RTL
======================

Name: bypass_scoreboard

Overview:
- Parametrised operand-bypass unit for the multi-issue pipeline's execute stage.
- Resolves each read port against NLANE producer lanes across NSTG post-execute stages, with a fixed age priority.
- A per-register scoreboard tracks outstanding long-latency writes (mul/div, cache-miss loads) and raises stall requests.
- Holds resolved operands in registers while execute is stalled, and snoops late-arriving producer data into the held copies.

Parameters:
- NLANE, 2, issue lanes (lane NLANE-1 is youngest within a stage)
- NSTG, 2, post-execute stages forwarded from (stage 0 = mem, youngest; NSTG-1 = wb)
- NRD, 4, operand read ports
- DW, 32, data width
- AW, 5, register address width
- CNT_W, 2, scoreboard outstanding-write counter width

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; cancels all outstanding long writes
- hold_en  in  1  execute stage stalled; hold operands
- p_en  in  NSTG*NLANE  producer writes a register
- p_ok  in  NSTG*NLANE  producer data valid this cycle (0 = load/result not yet available)
- p_addr  in  NSTG*NLANE*AW  producer destination register
- p_data  in  NSTG*NLANE*DW  producer result
- lw_set  in  NLANE  long-latency write issued, one per lane
- lw_set_addr  in  NLANE*AW  its destination register
- lw_done  in  1  a long-latency write retired to the register file
- lw_done_addr  in  AW  its register
- rd_addr  in  NRD*AW  operand register numbers
- rf_data  in  NRD*DW  register-file read data
- opnd  out  NRD*DW  resolved operands
- opnd_ok  out  NRD  operand valid
- stall_req  out  1  OR of ~opnd_ok

Behaviour:
- Reset (async, resetn=0):
  - all held operands 0; held-valid bits 0; all scoreboard counters 0.
  - outputs then follow the combinational rules below.
- Register 0:
  - rd_addr=0 gives opnd=0, opnd_ok=1 always, in both hold and non-hold mode.
  - lw_set/lw_done to register 0 are ignored.
  - p_en with p_addr=0 never matches.
- Resolution, per port, combinational, zero latency:
  - Scan stage 0 before stage 1, and so on; within a stage, scan lane NLANE-1 down to 0.
  - The first entry with p_en=1 and p_addr=rd_addr wins.
  - If the winner has p_ok=1: data = p_data, ok = 1.
  - If the winner has p_ok=0: ok = 0; an older match must NOT be used.
  - If there is no match: data = rf_data, ok = 1.
  - Finally, if scoreboard count[rd_addr] != 0 and there is no ok producer match, ok = 0.
- Scoreboard (registered, visible the cycle after the event):
  - Per-register counter.
  - lw_set increments; simultaneous sets from multiple lanes to the same register add their count.
  - lw_done decrements.
  - A set and a done to the same register in the same cycle add together (net change per the above).
  - Saturates at 2^CNT_W-1 and does not decrement below 0; both are simulation assertion errors.
  - flush clears all counters; flush beats same-cycle sets.
- Hold:
  - On the first cycle with hold_en=1, capture the current opnd/opnd_ok per port. The capture happens on the clk edge ending the last non-hold cycle: the value registered every non-hold cycle is used when hold_en rises.
  - While hold_en=1, outputs come from the held registers.
  - Each held port with ok=0 updates at every edge from a matching producer with p_ok=1, using the same priority, or from lw_done_addr==rd_addr with rf_data, and then becomes ok.
  - Held ports with ok=1 never change during hold.
  - Once hold_en falls, outputs return to combinational resolution the same cycle.
  - flush during hold: held ok bits are cleared to 1 with data 0; the stalled instruction is being killed anyway.
- stall_req is combinational from the currently driven opnd_ok.

Decomposition:
- Shared package: DW/AW defaults, the zero-register constant, lane/stage index helper functions, and a flattened-bus slice macro or function.
- One sub-module, bypass_prio_mux: a single read port's priority match over NSTG*NLANE entries, returning data, hit and ok. It is instantiated NRD times for resolution and reused for hold-mode snooping.

Test Plan:
1. rd_addr=5, stage0 lane1 {en,ok,addr=5,data=0xAAAA}, stage0 lane0 addr=5 data=0xBBBB -> opnd=0xAAAA, ok=1.
2. rd_addr=7, stage0 lane0 {addr=7,ok=0}, stage1 lane1 {addr=7,ok=1,data=0x11} -> ok=0, stall_req=1; next cycle stage0 ok=1 data=0x22 -> opnd=0x22.
3. lw_set addr=9, then rd_addr=9 with no producer match -> ok=0 until the cycle after lw_done addr=9; then opnd=rf_data.
4. Hold with port0 ok=0 on r3; during hold, wb lane0 writes r3=0x33 with ok=1 -> port0 becomes 0x33 at the next edge; port1 (ok) stays unchanged through 3 hold cycles.
5. rd_addr=0 with a producer p_addr=0 data=0xFF -> opnd=0, ok=1; lw_set to r0 leaves the scoreboard unchanged.
6. Two lw_set r4, then flush -> count[4]=0; assert resetn=0 mid-hold -> held data 0 and scoreboard cleared immediately.

Source files
------------

// File: rtl/bypass_scoreboard_pkg.sv
// Shared defaults and flattened-bus helpers for the operand-bypass / scoreboard block.
// Elaboration-time only; no logic lives here.
`ifndef BYPASS_SCOREBOARD_SLICE
`define BYPASS_SCOREBOARD_SLICE
`define BSB_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package bypass_scoreboard_pkg;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int ZERO_REG = 0;

  // Producer entries are flattened stage-major: entry = stage*NLANE + lane.
  function automatic int ent_idx(input int stg, input int lane, input int nlane);
    return stg * nlane + lane;
  endfunction

  function automatic int ent_stg(input int idx, input int nlane);
    return idx / nlane;
  endfunction

  function automatic int ent_lane(input int idx, input int nlane);
    return idx % nlane;
  endfunction
endpackage

// File: rtl/bypass_scoreboard_if.sv
// Execute-stage operand bus: producer forwarding, long-write tracking, read ports and results.
// master = pipeline control side, slave = bypass unit.
interface bypass_scoreboard_if
  import bypass_scoreboard_pkg::*;
#(
  parameter int NLANE = 2,
  parameter int NSTG  = 2,
  parameter int NRD   = 4,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
);
  logic                     flush;
  logic                     hold_en;
  logic [NSTG*NLANE-1:0]    p_en;
  logic [NSTG*NLANE-1:0]    p_ok;
  logic [NSTG*NLANE*AW-1:0] p_addr;
  logic [NSTG*NLANE*DW-1:0] p_data;
  logic [NLANE-1:0]         lw_set;
  logic [NLANE*AW-1:0]      lw_set_addr;
  logic                     lw_done;
  logic [AW-1:0]            lw_done_addr;
  logic [NRD*AW-1:0]        rd_addr;
  logic [NRD*DW-1:0]        rf_data;
  logic [NRD*DW-1:0]        opnd;
  logic [NRD-1:0]           opnd_ok;
  logic                     stall_req;

  modport master (
    output flush, hold_en, p_en, p_ok, p_addr, p_data,
           lw_set, lw_set_addr, lw_done, lw_done_addr, rd_addr, rf_data,
    input  opnd, opnd_ok, stall_req
  );

  modport slave (
    input  flush, hold_en, p_en, p_ok, p_addr, p_data,
           lw_set, lw_set_addr, lw_done, lw_done_addr, rd_addr, rf_data,
    output opnd, opnd_ok, stall_req
  );
endinterface

// File: rtl/bypass_prio_mux.sv
// One read port's age-priority match over all producer entries; combinational, zero latency.
// Stage 0 beats later stages, higher lane beats lower lane; register 0 never matches.
module bypass_prio_mux
  import bypass_scoreboard_pkg::*;
#(
  parameter int NLANE = 2,
  parameter int NSTG  = 2,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic [NSTG*NLANE-1:0]    p_en_i,
  input  logic [NSTG*NLANE-1:0]    p_ok_i,
  input  logic [NSTG*NLANE*AW-1:0] p_addr_i,
  input  logic [NSTG*NLANE*DW-1:0] p_data_i,
  input  logic [AW-1:0]            rd_addr_i,
  output logic [DW-1:0]            data_o,
  output logic                     hit_o,
  output logic                     ok_o
);
  always_comb begin
    data_o = '0;
    hit_o  = 1'b0;
    ok_o   = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int s = NSTG - 1; s >= 0; s--) begin
      for (int l = 0; l < NLANE; l++) begin
        if (p_en_i[ent_idx(s, l, NLANE)] && rd_addr_i != AW'(ZERO_REG) &&
            `BSB_SLICE(p_addr_i, ent_idx(s, l, NLANE), AW) == rd_addr_i) begin
          hit_o  = 1'b1;
          ok_o   = p_ok_i[ent_idx(s, l, NLANE)];
          data_o = `BSB_SLICE(p_data_i, ent_idx(s, l, NLANE), DW);
        end
      end
    end
  end
endmodule

// File: rtl/bypass_scoreboard.sv
// Operand bypass with long-write scoreboard and stall-time operand holding.
// Resolution is combinational; scoreboard and held operands update on the next edge.
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int NLANE = 2,
  parameter int NSTG  = 2,
  parameter int NRD   = 4,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               resetn,
  bypass_scoreboard_if.slave bus
);
  localparam int NREG    = 1 << AW;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  int               net_c [NREG];
  logic [NREG-1:0]  ovf_c;
  logic [NREG-1:0]  udf_c;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      net_c[r] = int'(cnt_q[r]);
      for (int l = 0; l < NLANE; l++) begin
        if (bus.lw_set[l] && `BSB_SLICE(bus.lw_set_addr, l, AW) == AW'(r))
          net_c[r] = net_c[r] + 1;
      end
      if (bus.lw_done && bus.lw_done_addr == AW'(r))
        net_c[r] = net_c[r] - 1;
      ovf_c[r] = 1'b0;
      udf_c[r] = 1'b0;
      if (bus.flush || r == ZERO_REG) begin
        cnt_d[r] = '0;
      end else if (net_c[r] > CNT_MAX) begin
        cnt_d[r] = CNT_W'(CNT_MAX);
        ovf_c[r] = 1'b1;
      end else if (net_c[r] < 0) begin
        cnt_d[r] = '0;
        udf_c[r] = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(net_c[r]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (ovf_c == '0);
      assert (udf_c == '0);
    end
  end

  logic [NRD-1:0][DW-1:0] opnd_drv;
  logic [NRD-1:0]         ok_drv;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [AW-1:0] rd;
    logic [DW-1:0] rf, mx_data, res_data, held_dat_q, held_dat_d;
    logic          mx_hit, mx_ok, fwd_ok, is_zero, done_hit;
    logic          res_ok, held_ok_q, held_ok_d;

    assign rd = `BSB_SLICE(bus.rd_addr, g, AW);
    assign rf = `BSB_SLICE(bus.rf_data, g, DW);

    // Same match serves live resolution and hold-time snooping; rd_addr is stable while stalled.
    bypass_prio_mux #(.NLANE(NLANE), .NSTG(NSTG), .DW(DW), .AW(AW)) u_mux (
      .p_en_i   (bus.p_en),
      .p_ok_i   (bus.p_ok),
      .p_addr_i (bus.p_addr),
      .p_data_i (bus.p_data),
      .rd_addr_i(rd),
      .data_o   (mx_data),
      .hit_o    (mx_hit),
      .ok_o     (mx_ok)
    );

    assign is_zero  = rd == AW'(ZERO_REG);
    assign fwd_ok   = mx_hit && mx_ok;
    assign done_hit = bus.lw_done && bus.lw_done_addr == rd && !is_zero;

    always_comb begin
      res_data = mx_hit ? mx_data : rf;
      res_ok   = !mx_hit || mx_ok;
      if (cnt_q[rd] != '0 && !fwd_ok) res_ok = 1'b0;
      if (is_zero) begin
        res_data = '0;
        res_ok   = 1'b1;
      end
    end

    always_comb begin
      held_dat_d = held_dat_q;
      held_ok_d  = held_ok_q;
      if (!bus.hold_en) begin
        held_dat_d = res_data;
        held_ok_d  = res_ok;
      end else if (bus.flush) begin
        held_dat_d = '0;
        held_ok_d  = 1'b1;
      end else if (!held_ok_q) begin
        if (fwd_ok) begin
          held_dat_d = mx_data;
          held_ok_d  = 1'b1;
        end else if (done_hit) begin
          held_dat_d = rf;
          held_ok_d  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        held_dat_q <= '0;
        held_ok_q  <= 1'b0;
      end else begin
        held_dat_q <= held_dat_d;
        held_ok_q  <= held_ok_d;
      end
    end

    assign opnd_drv[g] = (bus.hold_en && !is_zero) ? held_dat_q : res_data;
    assign ok_drv[g]   = (bus.hold_en && !is_zero) ? held_ok_q  : res_ok;
  end

  assign bus.opnd      = opnd_drv;
  assign bus.opnd_ok   = ok_drv;
  assign bus.stall_req = ~&ok_drv;
endmodule
